// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared opcodes, FSM state encoding, access-size type and
//             bus-field reset values for the memory access unit.
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  // Load/store opcodes (instr[31:26])
  localparam logic [5:0] c_op_lw  = 6'b100011;
  localparam logic [5:0] c_op_lh  = 6'b100001;
  localparam logic [5:0] c_op_lhu = 6'b100101;
  localparam logic [5:0] c_op_lb  = 6'b100000;
  localparam logic [5:0] c_op_lbu = 6'b100100;
  localparam logic [5:0] c_op_sw  = 6'b101011;
  localparam logic [5:0] c_op_sh  = 6'b101001;
  localparam logic [5:0] c_op_sb  = 6'b101000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  // Bus-field reset values
  localparam logic        c_rst_we    = 1'b0;
  localparam logic [31:0] c_rst_addr  = 32'h0000_0000;
  localparam logic [3:0]  c_rst_be    = 4'b0000;
  localparam logic [31:0] c_rst_wdata = 32'h0000_0000;

  // Byte-enable pattern for an access of the given size at lane offset lo
  function automatic logic [3:0] f_byte_en(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_WORD: return 4'b1111;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b0001 << lo;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// ============================================================================
//  Module   : load_ext
//  Purpose  : Selects the addressed byte/half lane of a read word and sign-
//             or zero-extends it to 32 bits.
//  Revision : 1.0  initial release
// ============================================================================
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lo,
  input  size_t       i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select and extension
  always_comb begin
    case (i_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      default: o_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : M-stage load/store controller. Issues one req/ack bus access
//             per memory instruction, stalls the pipeline until it completes,
//             and returns extended load data.
//  Options  : MEM_ALIGN_CHECK_EN - trap misaligned accesses (exc_adel/ades)
//             instead of masking the offending address bits.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_pc,
  input  logic [31:0] M_instr,
  input  logic [31:0] M_ALUout,
  input  logic [31:0] M_rt_rd,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] M_rdata,
  output logic        bus_err,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] M_err_pc
);

  localparam int                 c_cnt_w    = $clog2(BUS_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BUS_TIMEOUT - 1);

  state_t             r_state, w_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_we, r_signed, r_err;
  logic [31:0]        r_addr, r_wdata, r_rdata, r_err_pc;
  logic [3:0]         r_be;
  logic [1:0]         r_lo;
  size_t              r_size;

  logic        w_is_mem, w_is_store, w_signed, w_misalign, w_timeout, w_issue;
  size_t       w_size;
  logic [1:0]  w_lo;
  logic [31:0] w_wdata, w_ext;
  logic        w_unused;

  // Only the opcode field of the instruction matters here
  assign w_unused = &{1'b0, M_instr[25:0]};

  // Opcode decode
  always_comb begin
    w_is_mem   = 1'b0;
    w_is_store = 1'b0;
    w_size     = SZ_WORD;
    w_signed   = 1'b0;
    case (M_instr[31:26])
      c_op_lw:  w_is_mem = 1'b1;
      c_op_lh:  begin w_is_mem = 1'b1; w_size = SZ_HALF; w_signed = 1'b1; end
      c_op_lhu: begin w_is_mem = 1'b1; w_size = SZ_HALF; end
      c_op_lb:  begin w_is_mem = 1'b1; w_size = SZ_BYTE; w_signed = 1'b1; end
      c_op_lbu: begin w_is_mem = 1'b1; w_size = SZ_BYTE; end
      c_op_sw:  begin w_is_mem = 1'b1; w_is_store = 1'b1; end
      c_op_sh:  begin w_is_mem = 1'b1; w_is_store = 1'b1; w_size = SZ_HALF; end
      c_op_sb:  begin w_is_mem = 1'b1; w_is_store = 1'b1; w_size = SZ_BYTE; end
      default:  ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign w_lo       = M_ALUout[1:0];
  assign w_misalign = w_is_mem &&
                      (((w_size == SZ_WORD) && (w_lo != 2'b00)) ||
                       ((w_size == SZ_HALF) && w_lo[0]));
`else
  // Without trapping, misaligned low bits are simply dropped
  assign w_lo       = (w_size == SZ_WORD) ? 2'b00 :
                      (w_size == SZ_HALF) ? {M_ALUout[1], 1'b0} : M_ALUout[1:0];
  assign w_misalign = 1'b0;
`endif

  assign w_wdata = (w_size == SZ_WORD) ? M_rt_rd :
                   (w_size == SZ_HALF) ? {2{M_rt_rd[15:0]}} : {4{M_rt_rd[7:0]}};

  assign w_issue   = (r_state == S_IDLE) && w_is_mem && !w_misalign;
  assign w_timeout = (r_state == S_REQ) && !bus_ack && (r_cnt == c_cnt_last);

  load_ext u_load_ext (
    .i_rdata  (bus_rdata),
    .i_lo     (r_lo),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and stall
  always_comb begin
    w_next    = r_state;
    mem_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_stall = w_is_mem;
        if (w_is_mem) w_next = w_misalign ? S_DONE : S_REQ;
      end
      S_REQ: begin
        mem_stall = 1'b1;
        if (bus_ack || w_timeout) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bus fields and load-lane info latched when the request is issued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= c_rst_we;
      r_addr   <= c_rst_addr;
      r_be     <= c_rst_be;
      r_wdata  <= c_rst_wdata;
      r_lo     <= 2'b00;
      r_size   <= SZ_WORD;
      r_signed <= 1'b0;
    end else if (w_issue) begin
      r_we     <= w_is_store;
      r_addr   <= {M_ALUout[31:2], 2'b00};
      r_be     <= f_byte_en(w_size, w_lo);
      r_wdata  <= w_wdata;
      r_lo     <= w_lo;
      r_size   <= w_size;
      r_signed <= w_signed;
    end
  end

  // Timeout counter: cleared while idle, counts unacknowledged REQ cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              r_cnt <= '0;
    else if (r_state == S_IDLE)              r_cnt <= '0;
    else if ((r_state == S_REQ) && !bus_ack) r_cnt <= r_cnt + 1'b1;
  end

  // Load result, timeout pulse and faulting-PC capture (ack beats timeout)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
      r_err_pc <= 32'h0;
    end else begin
      r_err <= 1'b0;
      if ((r_state == S_IDLE) && w_misalign) begin
        r_rdata  <= 32'h0;
        r_err_pc <= M_pc;
      end else if ((r_state == S_REQ) && bus_ack) begin
        r_rdata <= w_ext;
      end else if (w_timeout) begin
        r_rdata  <= 32'h0;
        r_err    <= 1'b1;
        r_err_pc <= M_pc;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_adel, r_ades;

  // Misalignment exception pulses, visible in the DONE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_adel <= 1'b0;
      r_ades <= 1'b0;
    end else begin
      r_adel <= (r_state == S_IDLE) && w_misalign && !w_is_store;
      r_ades <= (r_state == S_IDLE) && w_misalign && w_is_store;
    end
  end

  assign exc_adel = r_adel;
  assign exc_ades = r_ades;
`else
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
`endif

  assign bus_req   = (r_state == S_REQ);
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_be    = r_be;
  assign bus_wdata = r_wdata;
  assign M_rdata   = r_rdata;
  assign bus_err   = r_err;
  assign M_err_pc  = r_err_pc;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit. Expected results are
//             queued when each access is driven and compared when it ends.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TO = 6;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_pc, M_instr, M_ALUout, M_rt_rd;
  logic        mem_stall, bus_req, bus_we, bus_ack, bus_err, exc_adel, exc_ades;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, M_rdata, M_err_pc;
  logic [3:0]  bus_be;

  mem_access_unit #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .M_pc(M_pc), .M_instr(M_instr),
    .M_ALUout(M_ALUout), .M_rt_rd(M_rt_rd), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .M_rdata(M_rdata), .bus_err(bus_err), .exc_adel(exc_adel),
    .exc_ades(exc_ades), .M_err_pc(M_err_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr, wdata, rdata, errpc;
    logic [3:0]  be;
    logic        we, err, adel, ades, chk_rdata;
    int          stalls, reqs;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_errpc = 32'h0;

  function automatic logic [31:0] f_load(input logic [5:0] op, input logic [1:0] lo,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      6'b100000: return {{24{b[7]}}, b};
      6'b100100: return {24'h0, b};
      6'b100001: return {{16{h[15]}}, h};
      6'b100101: return {16'h0, h};
      default:   return w;
    endcase
  endfunction

  // Drive one memory instruction, answer the bus, compare at the DONE cycle.
  // ack_at = index of the REQ cycle carrying bus_ack, or -1 for no ack.
  task automatic run_access(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] rt, input logic [31:0] pc,
                            input int ack_at, input logic [31:0] rdata);
    exp_t        e, g;
    int          sz, stalls, reqs, errs;
    bit          st, mis, done, stable;
    logic [1:0]  lo;
    logic [31:0] fa, fw;
    logic [3:0]  fb;
    logic        fwe;

    st  = op[3];
    sz  = (op[1:0] == 2'b11) ? 4 : (op[0] ? 2 : 1);
    mis = ((sz == 4) && (addr[1:0] != 2'b00)) || ((sz == 2) && addr[0]);
    lo  = addr[1:0];
    if (!ALIGN_CHK && sz == 4) lo = 2'b00;
    if (!ALIGN_CHK && sz == 2) lo[0] = 1'b0;
    e.addr = {addr[31:2], 2'b00};
    e.we   = st;
    case (sz)
      4:       begin e.be = 4'b1111; e.wdata = rt; end
      2:       begin e.be = lo[1] ? 4'b1100 : 4'b0011; e.wdata = {rt[15:0], rt[15:0]}; end
      default: begin
        e.wdata = {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
        case (lo)
          2'd0: e.be = 4'b0001; 2'd1: e.be = 4'b0010;
          2'd2: e.be = 4'b0100; default: e.be = 4'b1000;
        endcase
      end
    endcase
    e.err = 1'b0; e.adel = 1'b0; e.ades = 1'b0; e.chk_rdata = !st;
    if (ALIGN_CHK && mis) begin
      e.reqs = 0; e.stalls = 1; e.rdata = 32'h0; e.chk_rdata = 1'b1;
      e.adel = !st; e.ades = st; last_errpc = pc;
    end else if (ack_at < 0) begin
      e.reqs = TO; e.stalls = TO + 1; e.rdata = 32'h0; e.chk_rdata = 1'b1;
      e.err = 1'b1; last_errpc = pc;
    end else begin
      e.reqs = ack_at + 1; e.stalls = ack_at + 2; e.rdata = f_load(op, lo, rdata);
    end
    e.errpc = last_errpc;
    sb.push_back(e);

    M_instr = {op, 26'h0012345}; M_ALUout = addr; M_rt_rd = rt; M_pc = pc;
    bus_ack = 1'b0; bus_rdata = rdata;
    stalls = 0; reqs = 0; errs = 0; done = 1'b0; stable = 1'b1;
    fa = 32'h0; fw = 32'h0; fb = 4'h0; fwe = 1'b0;
    for (int cyc = 0; cyc < TO + 20 && !done; cyc++) begin
      #1;
      if (bus_req) begin
        if (reqs == 0) begin fa = bus_addr; fb = bus_be; fw = bus_wdata; fwe = bus_we; end
        else if (bus_addr !== fa || bus_be !== fb || bus_wdata !== fw || bus_we !== fwe) stable = 1'b0;
        reqs++;
        bus_ack = (ack_at == reqs - 1);
      end else begin
        bus_ack = 1'b0;
      end
      if (bus_err) errs++;
      if (mem_stall) stalls++;
      else done = 1'b1;
      if (!done) @(negedge clk);
    end
    bus_ack = 1'b0;
    if (!done) check_val({tag, " cycle budget"}, 32'd0, 32'd1);

    g = sb.pop_front();
    check_val({tag, " stalls"}, stalls, g.stalls);
    check_val({tag, " req cycles"}, reqs, g.reqs);
    check_val({tag, " bus_err pulses"}, errs, {31'h0, g.err});
    check_val({tag, " exc adel/ades"}, {30'h0, exc_adel, exc_ades}, {30'h0, g.adel, g.ades});
    check_val({tag, " M_err_pc"}, M_err_pc, g.errpc);
    if (g.chk_rdata) check_val({tag, " M_rdata"}, M_rdata, g.rdata);
    if (g.reqs > 0) begin
      check_val({tag, " bus_addr"}, fa, g.addr);
      check_val({tag, " bus_be"}, {28'h0, fb}, {28'h0, g.be});
      check_val({tag, " bus_we"}, {31'h0, fwe}, {31'h0, g.we});
      if (g.we) check_val({tag, " bus_wdata"}, fw, g.wdata);
      check_val({tag, " fields stable"}, {31'h0, stable}, 32'd1);
    end
    M_instr = 32'h0;
    @(negedge clk); #1;
    check_val({tag, " pulse ended"}, {29'h0, bus_err, exc_adel, exc_ades}, 32'h0);
  endtask

  initial begin
    int bad;
    reset = 1'b0; M_pc = 32'h0; M_instr = 32'h0; M_ALUout = 32'h0; M_rt_rd = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset bus_req/stall/err", {29'h0, bus_req, mem_stall, bus_err}, 32'h0);
    check_val("reset bus_addr", bus_addr, 32'h0);
    check_val("reset bus_be/we", {27'h0, bus_we, bus_be}, 32'h0);
    check_val("reset M_rdata", M_rdata, 32'h0);
    check_val("reset M_err_pc", M_err_pc, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    run_access("lw",        6'b100011, 32'h0000_1004, 32'h0,         32'h400, 0, 32'hDEAD_BEEF);
    run_access("lb",        6'b100000, 32'h0000_1003, 32'h0,         32'h404, 0, 32'h80FF_FF7F);
    run_access("lbu",       6'b100100, 32'h0000_1003, 32'h0,         32'h408, 0, 32'h80FF_FF7F);
    run_access("sh delay4", 6'b101001, 32'h0000_2002, 32'h1234_ABCD, 32'h40C, 4, 32'h0);
    run_access("lh",        6'b100001, 32'h0000_1002, 32'h0,         32'h410, 1, 32'h8001_7FFF);
    run_access("lhu",       6'b100101, 32'h0000_1000, 32'h0,         32'h414, 0, 32'h8001_7FFF);
    run_access("sb",        6'b101000, 32'h0000_3001, 32'h0000_005A, 32'h418, 0, 32'h0);
    run_access("sw",        6'b101011, 32'h0000_3000, 32'hCAFE_F00D, 32'h41C, 2, 32'h0);
    run_access("lw timeout",6'b100011, 32'h0000_5000, 32'h0,         32'h500, -1, 32'h0);
    run_access("lw ack@last",6'b100011,32'h0000_5004, 32'h0,         32'h504, TO - 1, 32'h1357_9BDF);
    run_access("lw misalign",6'b100011,32'h0000_1002, 32'h0,         32'h508, 0, 32'h1122_3344);
    run_access("sh misalign",6'b101001,32'h0000_2001, 32'h0000_BEEF, 32'h50C, 0, 32'h0);

    // Non-memory instruction with a stray ack: no stall, no request
    M_instr = 32'h0022_1821; bus_ack = 1'b1; bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (mem_stall || bus_req) bad++;
      @(negedge clk);
    end
    bus_ack = 1'b0; M_instr = 32'h0;
    check_val("non-mem stall/req", bad, 32'd0);

    // Reset while a store is waiting in REQ
    M_instr = {6'b101011, 26'h0}; M_ALUout = 32'h0000_4000; M_rt_rd = 32'h5555_AAAA;
    M_pc = 32'h600; bad = 0;
    for (int i = 0; i < 10 && !bus_req; i++) @(negedge clk);
    @(negedge clk);
    #1;
    check_val("pre-reset bus_req", {31'h0, bus_req}, 32'd1);
    reset = 1'b0;
    #1;
    check_val("async reset bus_req/we", {30'h0, bus_req, bus_we}, 32'h0);
    check_val("async reset bus_addr", bus_addr, 32'h0);
    check_val("async reset bus_wdata", bus_wdata, 32'h0);
    check_val("async reset be", {28'h0, bus_be}, 32'h0);
    check_val("async reset M_rdata", M_rdata, 32'h0);
    check_val("async reset M_err_pc", M_err_pc, 32'h0);
    M_instr = 32'h0;
    @(negedge clk);
    reset = 1'b1; last_errpc = 32'h0;
    @(negedge clk);
    run_access("lw after reset", 6'b100011, 32'h0000_7008, 32'h0, 32'h700, 1, 32'hA5A5_0F0F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute guard so the run always terminates
  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
